// File: rtl/fetch_unit.sv
// Instruction fetch for an RV32IC core: owns the PC, reads full words from
// instruction memory and presents one 16- or 32-bit instruction per cycle.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_step,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_compressed,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [0:0] {
        FETCH    = 1'b0,
        STRADDLE = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_START = {RESET_PC[ADDR_W-1:1], 1'b0};
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       buffer_reg, buffer_next;
    logic [31:0]       out_instr_reg, out_instr_next;
    logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
    logic              out_comp_reg, out_comp_next;
    logic              out_valid_reg, out_valid_next;

    logic        free;
    logic [15:0] lo_half;
    logic [15:0] hi_half;

    assign free    = !out_valid_reg || instr_ready;
    assign lo_half = imem_instr[15:0];
    assign hi_half = imem_instr[31:16];

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        buffer_next    = buffer_reg;
        out_instr_next = out_instr_reg;
        out_pc_next    = out_pc_reg;
        out_comp_next  = out_comp_reg;
        out_valid_next = out_valid_reg;

        if (redirect_valid) begin
            // Taken branch/jump discards any half-assembled or held instruction.
            state_next     = FETCH;
            pc_next        = {redirect_pc[ADDR_W-1:1], 1'b0};
            buffer_next    = '0;
            out_valid_next = 1'b0;
        end else if (free) begin
            case (state_reg)
                FETCH: begin
                    if (!pc_reg[1]) begin
                        out_valid_next = 1'b1;
                        out_pc_next    = pc_reg;
                        if (lo_half[1:0] != 2'b11) begin
                            out_instr_next = {16'h0000, lo_half};
                            out_comp_next  = 1'b1;
                            pc_next        = pc_reg + TWO;
                        end else begin
                            out_instr_next = imem_instr;
                            out_comp_next  = 1'b0;
                            pc_next        = pc_reg + FOUR;
                        end
                    end else if (hi_half[1:0] != 2'b11) begin
                        out_valid_next = 1'b1;
                        out_pc_next    = pc_reg;
                        out_instr_next = {16'h0000, hi_half};
                        out_comp_next  = 1'b1;
                        pc_next        = pc_reg + TWO;
                    end else begin
                        // Lower half of a 32-bit instruction; the rest is in the next word.
                        buffer_next    = hi_half;
                        pc_next        = pc_reg + TWO;
                        state_next     = STRADDLE;
                        out_valid_next = 1'b0;
                    end
                end
                STRADDLE: begin
                    out_valid_next = 1'b1;
                    out_pc_next    = pc_reg - TWO;
                    out_instr_next = {lo_half, buffer_reg};
                    out_comp_next  = 1'b0;
                    pc_next        = pc_reg + TWO;
                    state_next     = FETCH;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_reg        <= PC_START;
            buffer_reg    <= '0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
            out_comp_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            buffer_reg    <= buffer_next;
            out_instr_reg <= out_instr_next;
            out_pc_reg    <= out_pc_next;
            out_comp_reg  <= out_comp_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign imem_addr        = {pc_reg[ADDR_W-1:2], 2'b00};
    assign imem_step        = 1'b0;
    assign instr_out        = out_instr_reg;
    assign instr_pc         = out_pc_reg;
    assign instr_compressed = out_comp_reg;
    assign instr_valid      = out_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program-order reference walk fills a scoreboard
// queue; each accepted instruction is popped and compared.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_step;
    logic [31:0] imem_instr;
    logic [31:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_compressed;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        comp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_step        (imem_step),
        .imem_instr       (imem_instr),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] half_at(input logic [7:0] pc);
        logic [31:0] w;
        w = mem[pc[7:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Architectural walk of the instruction stream, independent of fetch timing.
    task automatic gen(input logic [7:0] start, input int n);
        logic [7:0]  pc;
        logic [15:0] h;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h    = half_at(pc);
            e.pc = pc;
            if (h[1:0] != 2'b11) begin
                e.instr = {16'h0000, h};
                e.comp  = 1'b1;
                pc      = pc + 8'd2;
            end else begin
                e.instr = {half_at(pc + 8'd2), h};
                e.comp  = 1'b0;
                pc      = pc + 8'd4;
            end
            q.push_back(e);
        end
    endtask

    // Called at a falling edge with inputs already set for the coming rising edge.
    task automatic tick();
        exp_t e;
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            if (q.size() == 0) begin
                check_eq("unexpected_accept", {32'h0, instr_out}, 64'hDEAD);
            end else begin
                e = q.pop_front();
                $display("accept pc=0x%02h instr=0x%08h c=%0d (exp pc=0x%02h instr=0x%08h c=%0d)",
                         instr_pc, instr_out, instr_compressed, e.pc, e.instr, e.comp);
                check_eq("instr", 64'(instr_out), 64'(e.instr));
                check_eq("pc", 64'(instr_pc), 64'(e.pc));
                check_eq("comp", 64'(instr_compressed), 64'(e.comp));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        instr_ready = 1'b0;
        check_eq("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic load_default();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic restart();
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        load_default();
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        @(negedge clk);

        // Reset state
        repeat (2) begin
            tick();
            check_eq("rst_valid", 64'(instr_valid), 64'd0);
            check_eq("rst_addr", 64'(imem_addr), 64'h00);
            check_eq("rst_out", 64'(instr_out), 64'h0);
            check_eq("rst_pc", 64'(instr_pc), 64'h0);
            check_eq("rst_comp", 64'(instr_compressed), 64'd0);
            check_eq("step", 64'(imem_step), 64'd0);
        end

        // Two full-width instructions
        rst         = 1'b0;
        instr_ready = 1'b1;
        gen(8'h00, 2);
        tick();
        check_eq("first_valid", 64'(instr_valid), 64'd1);
        check_eq("addr_step4", 64'(imem_addr), 64'h04);
        tick();
        check_eq("addr_step8", 64'(imem_addr), 64'h08);
        drain(10);

        // Two compressed instructions in one word
        load_default();
        mem[0] = 32'h4505_0001;
        restart();
        instr_ready = 1'b1;
        gen(8'h00, 3);
        tick();
        tick();
        check_eq("c_addr", 64'(imem_addr), 64'h04);
        drain(10);

        // Straddling 32-bit instruction with one bubble
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h0001_0000;
        restart();
        instr_ready = 1'b1;
        gen(8'h00, 3);
        tick();
        tick();
        check_eq("bubble", 64'(instr_valid), 64'd0);
        drain(10);

        // Backpressure holds everything, then resumes without loss
        load_default();
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        restart();
        tick();
        repeat (3) begin
            tick();
            check_eq("stall_valid", 64'(instr_valid), 64'd1);
            check_eq("stall_out", 64'(instr_out), 64'h13);
            check_eq("stall_pc", 64'(instr_pc), 64'h00);
            check_eq("stall_addr", 64'(imem_addr), 64'h04);
        end
        instr_ready = 1'b1;
        gen(8'h00, 3);
        drain(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_stall_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_stall_addr", 64'(imem_addr), 64'h00);

        // Redirect while a straddle half is buffered
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h0001_0000;
        mem[8] = 32'h00A0_0513;
        restart();
        instr_ready = 1'b1;
        gen(8'h00, 1);
        tick();
        tick();
        check_eq("q_before_redirect", 64'(q.size()), 64'd0);
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h21;
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_valid", 64'(instr_valid), 64'd0);
        check_eq("redir_addr", 64'(imem_addr), 64'h20);
        q.delete();
        gen(8'h20, 2);
        instr_ready = 1'b1;
        drain(10);

        // Straddle across the address wrap
        mem[63]        = 32'h0513_0000;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        check_eq("wrap_addr", 64'(imem_addr), 64'hFC);
        q.delete();
        gen(8'hFE, 4);
        instr_ready = 1'b1;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the RV32IC single-cycle core.
- Owns the PC and drives the instruction memory's byte address and step inputs. Consumes the 32-bit word the memory returns combinationally.
- Extracts 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Presents one instruction per cycle to decode over a valid/ready handshake, and accepts PC redirects from branch/jump logic.

Parameters:
- ADDR_W, 8: byte-address width of PC and memory address; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset; bit 0 forced to 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  word-aligned byte address to instruction memory: {fetch_pc[ADDR_W-1:2], 2'b00}.
- imem_step  output  1  instruction-memory half-word select; held 0 (full-word read), since half selection is done here.
- imem_instr  input  32  word returned by instruction memory, combinational from imem_addr.
- instr_out  output  32  instruction to decode; compressed instructions are zero-extended in [15:0].
- instr_pc  output  ADDR_W  byte address of instr_out.
- instr_compressed  output  1  instr_out is a 16-bit instruction.
- instr_valid  output  1  output register holds a valid instruction.
- instr_ready  input  1  decode accepts instr_out this cycle.
- redirect_valid  input  1  load new PC (branch/jump taken).
- redirect_pc  input  ADDR_W  redirect target; bit 0 ignored (treated as 0).

Behaviour:
- State: fetch_pc register, 16-bit half buffer, FSM {FETCH, STRADDLE}, and an output register (instr_out, instr_pc, instr_compressed, instr_valid).
- Reset: fetch_pc=RESET_PC&~1, FSM=FETCH, instr_valid=0, instr_out=0, instr_pc=0, instr_compressed=0, buffer=0. imem_step is always 0.
- Slot free condition: free = !instr_valid || instr_ready. When free=0, hold every register; the output stays stable.
- A half-word h is compressed iff h[1:0] != 2'b11.
- FETCH, free=1, fetch_pc[1]=0, lo=imem_instr[15:0]:
  - If lo is compressed: emit {16'b0,lo}, compressed=1, pc+=2.
  - Otherwise: emit imem_instr, compressed=0, pc+=4.
- FETCH, free=1, fetch_pc[1]=1, hi=imem_instr[31:16]:
  - If hi is compressed: emit {16'b0,hi}, pc+=2.
  - Otherwise: buffer<=hi, pc+=2 (now the next word), go to STRADDLE. Nothing is emitted; instr_valid<=0 if the slot was consumed.
- STRADDLE, free=1: emit {imem_instr[15:0], buffer}, instr_pc=fetch_pc-2, compressed=0, pc+=2, go to FETCH.
- "Emit" means load the output register with instr_valid<=1 and instr_pc<=current fetch_pc, except STRADDLE as above.
- Latency:
  - 1 cycle from imem_addr presentation to instr_valid.
  - A straddling instruction takes 2 cycles.
  - Sustained throughput with instr_ready=1 is 1 instruction/cycle, except straddles.
- Redirect (highest priority, overrides free and FSM):
  - Next edge: fetch_pc<=redirect_pc&~1, FSM=FETCH, instr_valid<=0. Buffered half and held output are discarded.
  - The first instruction from the target is valid 1 cycle later.
- Simultaneous reset and redirect: reset wins.
- PC arithmetic is modulo 2^ADDR_W. Wrap from 0xFE/0xFC to 0x00 is legal, including a straddle across the wrap: upper half at 0xFE, lower half from word 0x00, instr_pc=0xFE.
- Reset asserted mid-straddle or mid-stall returns to the reset state with no emission.

Test Plan:
1. Reset, rst=1 for 2 cycles, then release -> imem_addr=0x00, instr_valid=0 during reset; instr_valid=1 on the first cycle after release.
2. mem[0]=0x00000013, mem[1]=0x00100093, instr_ready=1 -> instr_out=0x00000013 @pc 0x00, then 0x00100093 @pc 0x04, compressed=0 for both; imem_addr steps 0x00,0x04,0x08.
3. mem[0]=0x45050001 -> 0x00000001 @0x00 (compressed=1), then 0x00004505 @0x02 (compressed=1), then imem_addr=0x04.
4. Straddle: mem[0]=0x00130001, mem[1]=0x00010000 -> 0x00000001 @0x00, one bubble cycle (instr_valid=0), then 0x00000013 @0x02 compressed=0, then 0x00000001 @0x06.
5. Backpressure: instr_ready=0 for 3 cycles while instr_valid=1 -> instr_out, instr_pc, imem_addr unchanged. On ready=1, the next instruction follows the next cycle with no loss or duplication.
6. Redirect during STRADDLE with instr_ready=0, redirect_pc=0x21 -> instr_valid=0 next cycle, imem_addr=0x20, next valid instr_pc=0x20; the stale buffered half never appears.
